pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register: one generic stage register for any inter-stage boundary (EX/MEM, MEM/WB, SPI-fetch/decode).
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a slow stage (e.g. SPI memory) stalls upstream without a combinational ready path.
- Adds a synchronous flush that kills in-flight entries and zeroes their control bits, suppressing RegWrite/MemWrite side effects.

Parameters:
- DATA_W, 96, width of the data payload (e.g. ALUResult+WriteData+PCPlus4).
- CTRL_W, 4, width of the control payload (e.g. RegWrite, ResultSrc[1:0], MemWrite); zeroed whenever the output is not valid.
- RD_W, 5, width of the destination-register field.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- flush_i  in  1  synchronous kill of all held entries and the incoming entry.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle; driven directly from a register.
- in_ctrl  in  CTRL_W  control payload.
- in_rd  in  RD_W  destination register.
- in_data  in  DATA_W  data payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0.
- out_rd  out  RD_W  head destination register.
- out_data  out  DATA_W  head data.

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_valid/in_* may change freely while in_ready=0.
- Storage: main slot (drives the outputs) and skid slot.
- States: EMPTY, ONE (main valid), FULL (main and skid valid).
- in_ready = (state != FULL), registered; out_valid = (state != EMPTY).
- Transitions, flush_i=0:
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire&out_fire -> ONE, main<=in. in_fire&!out_fire -> FULL, skid<=in. !in_fire&out_fire -> EMPTY. Otherwise hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. No input is accepted in FULL.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strictly FIFO; no entry is ever duplicated or dropped except by flush.
- flush_i=1 has top priority:
  - Next state is EMPTY, regardless of in_fire or out_fire that cycle.
  - The incoming entry is discarded.
  - in_ready=1 in the following cycle.
  - An out_fire coincident with flush still counts as consumed downstream (this stage holds no record of it).
- Control gating: out_ctrl = out_valid ? main_ctrl : 0, so bubbles and flushed slots never assert RegWrite/MemWrite.
- out_rd and out_data hold stale values while invalid; consumers must qualify them with out_valid.
- Reset (RST_N=0), asynchronous: state=EMPTY, in_ready=1 (reset value of the ready register), out_valid=0, out_ctrl=0, out_rd=0, out_data=0, skid payload=0.
- Reset mid-transfer: all held entries are lost. Leaving reset needs no special sequencing.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds output stall_cnt [31:0], a saturating count of cycles with out_valid & !out_ready.
  - Reset to 0; holds at 0xFFFF_FFFF once reached.
  - Not cleared by flush.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package pipe_pkg:
  - State enum (EMPTY/ONE/FULL).
  - Codebase widths: XLEN=32, REG_ADDR_W=5, MEM_CTRL_W=4.
  - Per-stage payload-width constants used for instantiation.
- One natural sub-module, pipe_slot: an async-reset payload register with load enable, holding ctrl/rd/data. It is instantiated twice (main, skid).

Test Plan:
- Reset then stream 0xA,0xB,0xC with out_ready=1 -> out_data A,B,C on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1.
- Accept A; hold out_ready=0; offer B -> B taken into skid, state FULL, in_ready=0 next cycle. Offer C while in_ready=0 -> not accepted. Raise out_ready -> outputs A then B; C accepted only after in_ready returns to 1.
- FULL with in_ctrl=4'b1001 entries, assert flush_i with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; nothing emerges.
- Simultaneous in_fire and out_fire in ONE -> state stays ONE, new entry on outputs next cycle, no bubble.
- Drop RST_N asynchronously mid-stream (between clock edges) -> out_valid=0 and out_ctrl=0 immediately; after release, stream restarts cleanly.
- With PIPE_STAGE_PERF_EN defined, hold out_valid=1/out_ready=0 for 7 cycles -> stall_cnt=7; force near 0xFFFF_FFFF -> saturates, no wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage states, codebase widths and the
// per-boundary payload widths used when instantiating pipe_stage_skid.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_CTRL_W = 4;

    // ALUResult + WriteData + PCPlus4
    localparam int EXMEM_DATA_W = 3 * XLEN;
    // ReadData + ALUResult + PCPlus4
    localparam int MEMWB_DATA_W = 3 * XLEN;
    // Instr + PC
    localparam int FETCH_DATA_W = 2 * XLEN;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    function automatic logic state_accepts(input pipe_state_e s);
        return (s != FULL);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register (ctrl/rd/data) with load enable and async active-low
// reset to zero; used as both the main and the skid slot of a stage.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = MEM_CTRL_W,
    parameter int RD_W   = REG_ADDR_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [RD_W-1:0]   rd_d,   rd_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Select new payload on load, otherwise hold.
    always_comb begin
        if (load_i) begin
            ctrl_d = ctrl_i;
            rd_d   = rd_i;
            data_d = data_i;
        end else begin
            ctrl_d = ctrl_q;
            rd_d   = rd_q;
            data_d = data_q;
        end
    end

    // Payload storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds a saturating stall_cnt output.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = MEM_CTRL_W,
    parameter int RD_W   = REG_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    pipe_state_e state_d, state_q;
    logic        in_ready_d, in_ready_q;
    logic        in_fire_s, out_fire_s;
    logic        main_load_s, main_from_skid_s, skid_load_s;

    logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_ctrl_in_s;
    logic [RD_W-1:0]   main_rd_s,   skid_rd_s,   main_rd_in_s;
    logic [DATA_W-1:0] main_data_s, skid_data_s, main_data_in_s;

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and slot-load decode; flush overrides every handshake.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_d     = FULL;
                        skid_load_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        state_d          = ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = state_accepts(state_d);
    end

    // Main slot refills from the skid when draining FULL, else from upstream.
    always_comb begin
        if (main_from_skid_s) begin
            main_ctrl_in_s = skid_ctrl_s;
            main_rd_in_s   = skid_rd_s;
            main_data_in_s = skid_data_s;
        end else begin
            main_ctrl_in_s = in_ctrl;
            main_rd_in_s   = in_rd;
            main_data_in_s = in_data;
        end
    end

    // State and ready registers; ready has no combinational path from out_ready.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W)) u_main (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load_i (main_load_s),
        .ctrl_i (main_ctrl_in_s),
        .rd_i   (main_rd_in_s),
        .data_i (main_data_in_s),
        .ctrl_o (main_ctrl_s),
        .rd_o   (main_rd_s),
        .data_o (main_data_s)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W)) u_skid (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load_i (skid_load_s),
        .ctrl_i (in_ctrl),
        .rd_i   (in_rd),
        .data_i (in_data),
        .ctrl_o (skid_ctrl_s),
        .rd_o   (skid_rd_s),
        .data_o (skid_data_s)
    );

    // Bubbles and flushed slots must never present live control bits.
    assign out_ctrl = out_valid ? main_ctrl_s : {CTRL_W{1'b0}};
    assign out_rd   = main_rd_s;
    assign out_data = main_data_s;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Saturating stall counter; deliberately unaffected by flush.
    always_comb begin
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, async reset
// sequence, randomized run against a queue model, optional stall counter.
module tb_pipe_stage_skid;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic [95:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_skid dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [95:0] data;
    } ent_t;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [7:0] tag;
        logic [3:0] ctrl;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_tag;
        logic [3:0] e_ctrl;
    } vec_t;

    ent_t mq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] tag_data(input logic [7:0] t);
        return {t, 80'h0, t};
    endfunction

    task automatic apply_reset();
        RST_N     = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = 4'h0;
        in_rd     = 5'h0;
        in_data   = 96'h0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        mq.delete();
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [7:0] tag, input logic [3:0] ctrl);
        in_valid  = iv;
        out_ready = ordy;
        flush_i   = fl;
        in_ctrl   = ctrl;
        in_rd     = tag[4:0];
        in_data   = tag_data(tag);
    endtask

    vec_t tbl[18];

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 8'h0A, 4'h1,  1'b1, 1'b1, 8'h0A, 4'h1},
            '{1'b1, 1'b1, 1'b0, 8'h0B, 4'h2,  1'b1, 1'b1, 8'h0B, 4'h2},
            '{1'b1, 1'b1, 1'b0, 8'h0C, 4'h3,  1'b1, 1'b1, 8'h0C, 4'h3},
            '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0,  1'b0, 1'b1, 8'h00, 4'h0},
            '{1'b1, 1'b0, 1'b0, 8'h0A, 4'h1,  1'b1, 1'b1, 8'h0A, 4'h1},
            '{1'b1, 1'b0, 1'b0, 8'h0B, 4'h2,  1'b1, 1'b0, 8'h0A, 4'h1},
            '{1'b1, 1'b0, 1'b0, 8'h0C, 4'h3,  1'b1, 1'b0, 8'h0A, 4'h1},
            '{1'b1, 1'b1, 1'b0, 8'h0C, 4'h3,  1'b1, 1'b1, 8'h0B, 4'h2},
            '{1'b1, 1'b1, 1'b0, 8'h0C, 4'h3,  1'b1, 1'b1, 8'h0C, 4'h3},
            '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0,  1'b0, 1'b1, 8'h00, 4'h0},
            '{1'b1, 1'b0, 1'b0, 8'h0D, 4'h9,  1'b1, 1'b1, 8'h0D, 4'h9},
            '{1'b1, 1'b0, 1'b0, 8'h0E, 4'h9,  1'b1, 1'b0, 8'h0D, 4'h9},
            '{1'b1, 1'b0, 1'b1, 8'h0F, 4'h9,  1'b0, 1'b1, 8'h00, 4'h0},
            '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0,  1'b0, 1'b1, 8'h00, 4'h0},
            '{1'b1, 1'b0, 1'b0, 8'h10, 4'h5,  1'b1, 1'b1, 8'h10, 4'h5},
            '{1'b1, 1'b1, 1'b1, 8'h11, 4'h5,  1'b0, 1'b1, 8'h00, 4'h0},
            '{1'b1, 1'b1, 1'b0, 8'h12, 4'h6,  1'b1, 1'b1, 8'h12, 4'h6},
            '{1'b0, 1'b1, 1'b0, 8'h00, 4'h0,  1'b0, 1'b1, 8'h00, 4'h0}
        };

        apply_reset();
        chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset_in_ready",  128'(in_ready),  128'(1'b1));
        chk("reset_out_ctrl",  128'(out_ctrl),  128'(4'h0));
        chk("reset_out_rd",    128'(out_rd),    128'(5'h0));
        chk("reset_out_data",  128'(out_data),  128'(96'h0));

        // Directed table: each row is applied for one cycle, checked after the edge.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].tag, tbl[i].ctrl);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_in_ready", i),  128'(in_ready),  128'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_ctrl", i),  128'(out_ctrl),  128'(tbl[i].e_ctrl));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_data", i), 128'(out_data), 128'(tag_data(tbl[i].e_tag)));
                chk($sformatf("tbl%0d_out_rd", i),   128'(out_rd),   128'(tbl[i].e_tag[4:0]));
            end
        end

        // Asynchronous reset between clock edges while holding an entry.
        drive(1'b1, 1'b0, 1'b0, 8'h2A, 4'hF);
        @(posedge CLK);
        #2;
        chk("pre_arst_valid", 128'(out_valid), 128'(1'b1));
        RST_N = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_out_ctrl",  128'(out_ctrl),  128'(4'h0));
        chk("arst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("arst_out_data",  128'(out_data),  128'(96'h0));
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h3B, 4'h4);
        @(posedge CLK);
        @(negedge CLK);
        chk("post_arst_valid", 128'(out_valid), 128'(1'b1));
        chk("post_arst_data",  128'(out_data),  128'(tag_data(8'h3B)));
        chk("post_arst_ctrl",  128'(out_ctrl),  128'(4'h4));

        // Randomized traffic against a FIFO-of-at-most-two reference model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            logic exp_ir, exp_ov, iv, ordy, fl, inf, outf;
            ent_t e;
            exp_ir = (mq.size() < 2);
            exp_ov = (mq.size() > 0);
            chk("rnd_out_valid", 128'(out_valid), 128'(exp_ov));
            chk("rnd_in_ready",  128'(in_ready),  128'(exp_ir));
            chk("rnd_out_ctrl",  128'(out_ctrl),  exp_ov ? 128'(mq[0].ctrl) : 128'(4'h0));
            if (exp_ov) begin
                chk("rnd_out_data", 128'(out_data), 128'(mq[0].data));
                chk("rnd_out_rd",   128'(out_rd),   128'(mq[0].rd));
            end
            iv     = ($urandom_range(9, 0) < 7);
            ordy   = ($urandom_range(9, 0) < 6);
            fl     = ($urandom_range(15, 0) == 0);
            e.ctrl = 4'($urandom);
            e.rd   = 5'($urandom);
            e.data = {$urandom, $urandom, $urandom};
            in_valid  = iv;
            out_ready = ordy;
            flush_i   = fl;
            in_ctrl   = e.ctrl;
            in_rd     = e.rd;
            in_data   = e.data;
            inf  = iv && exp_ir;
            outf = exp_ov && ordy;
            if (fl) begin
                mq.delete();
            end else begin
                if (outf) void'(mq.pop_front());
                if (inf)  mq.push_back(e);
            end
            @(posedge CLK);
            @(negedge CLK);
        end

`ifdef PIPE_STAGE_PERF_EN
        apply_reset();
        chk("stall_reset", 128'(stall_cnt), 128'(32'd0));
        drive(1'b1, 1'b0, 1'b0, 8'h44, 4'h1);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        repeat (7) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("stall_7", 128'(stall_cnt), 128'(32'd7));
        drive(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("stall_after_flush", 128'(stall_cnt), 128'(32'd8));
        drive(1'b1, 1'b0, 1'b0, 8'h45, 4'h2);
        @(posedge CLK);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("stall_saturate", 128'(stall_cnt), 128'(32'hFFFF_FFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
